vga_scan_mixer: RTL and testbench

Scan-side counterpart to the sprite layer. It generates 640x480@60 VGA timing from a divided pixel tick and drives `pixel_x`/`pixel_y` to the layer blocks. It then samples their registered `sprite_en`/`sprite` answers and composites them over a background colour into the registered RGB, sync and blank outputs. It sits between the layer blocks and the DAC/pin interface.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_sync_counter.sv | 76 +++++++
 rtl/vga_scan_mixer.sv | 132 +++++++++++++
 tb/tb_vga_scan_mixer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared types and constants for the VGA scan side and the layer
//           blocks. Holds the default 640x480@60 timing, the named colours
//           and the quadrant-centre coordinates.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package vga_pkg;

  typedef logic [23:0] rgb24_t;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480@60 timing, in pixel ticks / lines
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam rgb24_t COLOR_WHITE = 24'hFFFFFF;
  localparam rgb24_t COLOR_BLACK = 24'h000000;

  // Quadrant centre lines of the default active area
  localparam int VGA_QUAD_X = VGA_H_ACTIVE / 2;
  localparam int VGA_QUAD_Y = VGA_V_ACTIVE / 2;

endpackage
`default_nettype wire

// File: rtl/vga_sync_counter.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_counter
// Purpose : Pixel-tick divider plus horizontal/vertical scan counters.
// Ports   : clk, rst_n (async, active-low)
//           pixel_x/pixel_y  - current scan coordinate
//           pix_tick         - one-clk strobe, counters advance on its edge
//           frame_start      - pix_tick of the wrap to (0,0)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam coord_t c_x_last = COORD_W'(H_TOTAL - 1);
  localparam coord_t c_y_last = COORD_W'(V_TOTAL - 1);

  logic [c_div_w-1:0] div_q, div_d;
  coord_t             x_q, x_d;
  coord_t             y_q, y_d;
  logic               w_tick;
  logic               w_x_wrap;
  logic               w_y_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  always_comb begin
    w_tick   = (div_q == c_div_last);
    w_x_wrap = (x_q == c_x_last);
    w_y_wrap = (y_q == c_y_last);
    div_d    = w_tick ? '0 : div_q + c_div_w'(1);
    x_d      = x_q;
    y_d      = y_q;
    if (w_tick) begin
      if (w_x_wrap) begin
        x_d = '0;
        y_d = w_y_wrap ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  // Tick is decoded straight from the divider so it is low in reset and
  // high exactly on the clk whose edge moves the counters.
  assign pix_tick    = w_tick;
  assign frame_start = w_tick && w_x_wrap && w_y_wrap;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;

endmodule
`default_nettype wire

// File: rtl/vga_scan_mixer.sv
`default_nettype none
// ============================================================================
// Module  : vga_scan_mixer
// Purpose : VGA scan generator and final compositor. Drives the scan
//           coordinate to the layer blocks, samples their registered answer
//           on each pixel tick and produces registered RGB/sync/blank.
// Ports   : clk, rst_n (async, active-low)
//           bg_color, sprite_en, sprite  - background and layer answer in
//           pixel_x, pixel_y, pix_tick   - scan coordinate out
//           hsync, vsync, blank_n, rgb   - registered video out
//           frame_start                  - pulse on wrap to (0,0)
// Config  : VGA_QUADRANT_GRID_EN - white centre cross over the background
// Revision: 1.0 - initial release
// ============================================================================
module vga_scan_mixer
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] bg_color,
  input  logic        sprite_en,
  input  logic [23:0] sprite,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [23:0] rgb,
  output logic        frame_start
);

  localparam int     c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t c_h_active = COORD_W'(H_ACTIVE);
  localparam coord_t c_v_active = COORD_W'(V_ACTIVE);
  localparam coord_t c_hs_start = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t c_hs_end   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t c_vs_start = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t c_vs_end   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_QUADRANT_GRID_EN
  localparam coord_t c_quad_x   = COORD_W'(H_ACTIVE / 2);
  localparam coord_t c_quad_y   = COORD_W'(V_ACTIVE / 2);
`endif

  coord_t w_x;
  coord_t w_y;
  logic   w_tick;
  logic   w_active;
  rgb24_t w_bg;

  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   blank_n_q, blank_n_d;
  rgb24_t rgb_q, rgb_d;

  vga_sync_counter #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (c_h_total),
    .V_TOTAL (c_v_total)
  ) u_sync_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_x     (w_x),
    .pixel_y     (w_y),
    .pix_tick    (w_tick),
    .frame_start (frame_start)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= COLOR_BLACK;
    end else begin
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  // All decode uses the coordinate still on the counters at the tick edge,
  // i.e. the one being left, so every output lags the scan by one tick.
  always_comb begin
    w_active = (w_x < c_h_active) && (w_y < c_v_active);
    w_bg     = bg_color;
`ifdef VGA_QUADRANT_GRID_EN
    if ((w_x == c_quad_x) || (w_y == c_quad_y)) begin
      w_bg = COLOR_WHITE;
    end
`endif
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (w_tick) begin
      hsync_d   = !((w_x >= c_hs_start) && (w_x < c_hs_end));
      vsync_d   = !((w_y >= c_vs_start) && (w_y < c_vs_end));
      blank_n_d = w_active;
      // Blank beats sprite, sprite beats background (and grid).
      if (!w_active) begin
        rgb_d = COLOR_BLACK;
      end else if (sprite_en) begin
        rgb_d = sprite;
      end else begin
        rgb_d = w_bg;
      end
    end
  end

  assign pixel_x  = w_x;
  assign pixel_y  = w_y;
  assign pix_tick = w_tick;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign blank_n  = blank_n_q;
  assign rgb      = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_mixer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_scan_mixer
// Purpose : Self-checking bench for vga_scan_mixer using a reduced timing
//           set (80x56 total) so complete lines and frames fit a short run.
//           A behavioural layer answers one clk after each coordinate and
//           drives random garbage on non-tick clks.
// Config  : VGA_QUADRANT_GRID_EN honoured by the reference model
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_scan_mixer;

  localparam int CLK_DIV = 2;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] bg_color;
  logic        sprite_en;
  logic [23:0] sprite;
  logic [9:0]  pixel_x, pixel_y;
  logic        pix_tick, hsync, vsync, blank_n, frame_start;
  logic [23:0] rgb;

  always #5 clk = ~clk;

  vga_scan_mixer #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bg_color    (bg_color),
    .sprite_en   (sprite_en),
    .sprite      (sprite),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pix_tick    (pix_tick),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: k = clk edges since release, n = ticks taken.
  int          k, n, mode;
  logic        p_hit;
  logic [23:0] p_col, p_bg;
  logic        e_blank, e_hs, e_vs;
  logic [23:0] e_rgb;
  logic        ticked;
  int          lx, ly;
  int          hs_cnt, hb_cnt, vs_cnt, prev_fs_k;
  logic        prev_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bg_eff(input int x, input int y, input logic [23:0] bg);
`ifdef VGA_QUADRANT_GRID_EN
    if (x == HA / 2 || y == VA / 2) return 24'hFFFFFF;
`endif
    return bg;
  endfunction

  task automatic init_model();
    k = 0; n = 0;
    e_blank = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 24'h0;
    hs_cnt = 0; hb_cnt = 0; vs_cnt = 0; prev_fs_k = -1; prev_hs = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_x"}, pixel_x, 0);
    chk({tag, "_y"}, pixel_y, 0);
    chk({tag, "_tick"}, pix_tick, 0);
    chk({tag, "_hs"}, hsync, 1);
    chk({tag, "_vs"}, vsync, 1);
    chk({tag, "_blank_n"}, blank_n, 0);
    chk({tag, "_rgb"}, rgb, 0);
    chk({tag, "_fs"}, frame_start, 0);
  endtask

  // Layer answer for the coordinate on the counters, driven on the clk before
  // the tick edge; any other clk gets random garbage that must be ignored.
  task automatic drive();
    if (rst_n && ((k + 1) % CLK_DIV == 0)) begin
      int cx = n % HT;
      int cy = (n / HT) % VT;
      if (mode == 0) begin
        p_hit = (cx >= 20 && cx < 36 && cy >= 10 && cy < 26) || cx == 70;
        p_col = 24'h000000;
        p_bg  = 24'h123456;
      end else begin
        p_hit = ($urandom_range(0, 3) == 0) || cx == 70;
        p_col = 24'($urandom);
        p_bg  = 24'($urandom);
      end
      sprite_en = p_hit;
      sprite    = p_col;
      bg_color  = p_bg;
    end else begin
      sprite_en = 1'($urandom);
      sprite    = 24'($urandom);
      bg_color  = 24'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    ticked = 1'b0;
    if (k % CLK_DIV == 0) begin
      lx = n % HT;
      ly = (n / HT) % VT;
      e_blank = (lx < HA) && (ly < VA);
      e_hs    = !(lx >= HA + HF && lx < HA + HF + HS);
      e_vs    = !(ly >= VA + VF && ly < VA + VF + VS);
      e_rgb   = !e_blank ? 24'h0 : (p_hit ? p_col : bg_eff(lx, ly, p_bg));
      n++;
      ticked = 1'b1;
    end
    #1;
    chk("pixel_x", pixel_x, n % HT);
    chk("pixel_y", pixel_y, (n / HT) % VT);
    chk("pix_tick", pix_tick, (k % CLK_DIV) == CLK_DIV - 1);
    chk("frame_start", frame_start,
        ((k % CLK_DIV) == CLK_DIV - 1) && (n % HT == HT - 1) && ((n / HT) % VT == VT - 1));
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("blank_n", blank_n, e_blank);
    chk("rgb", rgb, e_rgb);
    if (ticked) begin
      if (!hsync) begin
        if (prev_hs) chk("hs_start_x", lx, HA + HF);
        hs_cnt++;
      end
      prev_hs = hsync;
      if (blank_n) hb_cnt++;
      if (!vsync) vs_cnt++;
      if (lx == HT - 1) begin
        chk("hs_width", hs_cnt, HS);
        chk("active_width", hb_cnt, (ly < VA) ? HA : 0);
        hs_cnt = 0;
        hb_cnt = 0;
        if (ly == VT - 1) begin
          chk("vs_width", vs_cnt, VS * HT);
          vs_cnt = 0;
        end
      end
    end
    if (frame_start) begin
      if (prev_fs_k >= 0) chk("fs_period", k - prev_fs_k, FRAME_CLK);
      prev_fs_k = k;
    end
    drive();
  endtask

  initial begin
    mode = 0;
    init_model();
    rst_n = 1'b1;
    sprite_en = 1'b0; sprite = 24'h0; bg_color = 24'h0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("por");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_reset("rst_hold");
      drive();
    end

    // Release; first tick on clk 1 (advance on edge 2), then x=1.
    rst_n = 1'b1;
    init_model();
    drive();
    step();
    chk("first_tick", pix_tick, 1);
    step();
    chk("x_after_first_tick", pixel_x, 1);

    // Deterministic sprite square over 0x123456 for a full frame and more.
    for (int i = 0; i < FRAME_CLK + 240; i++) step();

    // Random layer answers, colours and background.
    mode = 1;
    for (int i = 0; i < FRAME_CLK; i++) step();

    // Advance to the tick clk of (40,30), then pull reset mid-cycle.
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      if (n % HT == 40 && (n / HT) % VT == 30 && (k % CLK_DIV) == CLK_DIV - 1) break;
      step();
    end
    chk("reached_40_30", {pixel_y, pixel_x}, {10'd30, 10'd40});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset("mid_rst_hold");
      drive();
    end
    rst_n = 1'b1;
    mode = 0;
    init_model();
    drive();
    for (int i = 0; i < 2 * HT * CLK_DIV + 40; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
